// File: rtl/switch_debounce16.sv
// rtl/switch_debounce16.sv - 16-bit switch debouncer with per-bit stability counters.
// Optional sticky edge latch (edge_latch/edge_clear) enabled by DEBOUNCE_EDGE_LATCH_EN.
module switch_debounce16 #(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          SYNC_STAGES     = 2,
    parameter logic [15:0] RESET_VALUE     = 16'h0000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [15:0] raw_in,
`ifdef DEBOUNCE_EDGE_LATCH_EN
    input  logic [15:0] edge_clear,
    output logic [15:0] edge_latch,
`endif
    output logic [15:0] db_out,
    output logic        db_changed,
    output logic [15:0] change_mask
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [15:0]   sync_q [SYNC_STAGES];
    logic [15:0]   synced;
    logic [CW-1:0] cnt_q [16];
    logic [CW-1:0] cnt_d [16];
    logic [15:0]   upd;

    // Synchroniser chain; resets to RESET_VALUE so no spurious disagreement after reset.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Disagreeing sample that completes the run flips the bit; the count clears either way.
    always_comb begin
        upd = '0;
        for (int b = 0; b < 16; b++) begin
            cnt_d[b] = '0;
            if (synced[b] != db_out[b]) begin
                if (cnt_q[b] == CNT_LAST) begin
                    upd[b] = 1'b1;
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int b = 0; b < 16; b++) begin
                cnt_q[b] <= '0;
            end
            db_out      <= RESET_VALUE;
            db_changed  <= 1'b0;
            change_mask <= '0;
        end else begin
            for (int b = 0; b < 16; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            db_out      <= db_out ^ upd;
            db_changed  <= |upd;
            change_mask <= upd;
        end
    end

`ifdef DEBOUNCE_EDGE_LATCH_EN
    // Set has priority over a coincident clear.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            edge_latch <= '0;
        end else begin
            edge_latch <= (edge_latch & ~edge_clear) | upd;
        end
    end
`endif

endmodule

// File: tb/tb_switch_debounce16.sv
// tb/tb_switch_debounce16.sv - self-checking bench for switch_debounce16 (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// Edge latch checks are included when DEBOUNCE_EDGE_LATCH_EN is defined.
module tb_switch_debounce16;

    localparam int DC = 4;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] raw;
    logic [15:0] db_out;
    logic        db_changed;
    logic [15:0] change_mask;

    logic        rst2_n;
    logic [15:0] raw2;
    logic [15:0] db2;
    logic        chg2;
    logic [15:0] mask2;

    logic [15:0] clr_cur;
`ifdef DEBOUNCE_EDGE_LATCH_EN
    logic [15:0] edge_latch;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: a bit flips when its last DC synced samples (each the raw value
    // seen SS edges earlier) all differ from it and it has not flipped within that window.
    logic [15:0] m_db, m_mask, m_latch;
    logic        m_chg;
    logic [15:0] pipe[$];
    logic [15:0] win[$];
    int          last_upd[16];
    int          n;

    always #5 clk = ~clk;

    switch_debounce16 #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS), .RESET_VALUE(16'h0000)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .raw_in        (raw),
`ifdef DEBOUNCE_EDGE_LATCH_EN
        .edge_clear    (clr_cur),
        .edge_latch    (edge_latch),
`endif
        .db_out        (db_out),
        .db_changed    (db_changed),
        .change_mask   (change_mask)
    );

    switch_debounce16 #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS), .RESET_VALUE(16'hFFFF)) dut2 (
        .clk_clk       (clk),
        .reset_reset_n (rst2_n),
        .raw_in        (raw2),
`ifdef DEBOUNCE_EDGE_LATCH_EN
        .edge_clear    (16'h0000),
        .edge_latch    (),
`endif
        .db_out        (db2),
        .db_changed    (chg2),
        .change_mask   (mask2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_db = 16'h0000; m_mask = '0; m_chg = 1'b0; m_latch = '0;
        pipe.delete();
        for (int i = 0; i < SS; i++) pipe.push_back(16'h0000);
        win.delete();
        for (int b = 0; b < 16; b++) last_upd[b] = 0;
        n = 0;
    endfunction

    function automatic void model_edge(input logic [15:0] v, input logic [15:0] clr);
        logic [15:0] s, u;
        logic        ok;
        n++;
        pipe.push_back(v);
        s = pipe.pop_front();
        win.push_back(s);
        if (win.size() > DC) void'(win.pop_front());
        u = '0;
        for (int b = 0; b < 16; b++) begin
            if (n - last_upd[b] >= DC) begin
                ok = 1'b1;
                foreach (win[k]) if (win[k][b] == m_db[b]) ok = 1'b0;
                if (ok) begin
                    u[b] = 1'b1;
                    last_upd[b] = n;
                end
            end
        end
        m_db    = m_db ^ u;
        m_chg   = |u;
        m_mask  = u;
        m_latch = (m_latch & ~clr) | u;
    endfunction

    task automatic tick(input logic [15:0] v);
        raw = v;
        @(posedge clk);
        model_edge(v, clr_cur);
        @(negedge clk);
        chk("model_db_out", db_out, m_db);
        chk("model_db_changed", {15'b0, db_changed}, {15'b0, m_chg});
        chk("model_change_mask", change_mask, m_mask);
`ifdef DEBOUNCE_EDGE_LATCH_EN
        chk("model_edge_latch", edge_latch, m_latch);
`endif
    endtask

    // Asserted mid-cycle so only an asynchronous reset clears the outputs before the check.
    task automatic arst();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_db_out", db_out, 16'h0000);
        chk("arst_db_changed", {15'b0, db_changed}, 16'h0000);
        chk("arst_change_mask", change_mask, 16'h0000);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] r;
        rst_n = 1'b0; rst2_n = 1'b0; raw = '0; raw2 = '0; clr_cur = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_db_out", db_out, 16'h0000);
        chk("reset_db_changed", {15'b0, db_changed}, 16'h0000);
        chk("reset_change_mask", change_mask, 16'h0000);
        chk("reset_db2", db2, 16'hFFFF);
        rst_n = 1'b1; rst2_n = 1'b1;
        chk("release_db2", db2, 16'hFFFF);

        // Single-bit step on dut, and RESET_VALUE=FFFF with raw 0 on dut2.
        for (int i = 1; i <= 7; i++) begin
            tick(16'h0001);
            chk("step_db_out", db_out, (i >= 6) ? 16'h0001 : 16'h0000);
            chk("step_changed", {15'b0, db_changed}, (i == 6) ? 16'h0001 : 16'h0000);
            chk("step_mask", change_mask, (i == 6) ? 16'h0001 : 16'h0000);
            chk("rv_db2", db2, (i >= 6) ? 16'h0000 : 16'hFFFF);
            chk("rv_mask2", mask2, (i == 6) ? 16'hFFFF : 16'h0000);
            chk("rv_changed2", {15'b0, chg2}, (i == 6) ? 16'h0001 : 16'h0000);
        end

        // Three-cycle glitch on bit3 must be rejected.
        for (int i = 1; i <= 9; i++) begin
            tick((i <= 3) ? 16'h0009 : 16'h0001);
            chk("glitch_db_out", db_out, 16'h0001);
            chk("glitch_changed", {15'b0, db_changed}, 16'h0000);
        end

        // Multi-bit simultaneous step gives one pulse.
        raw = 16'h0000;
        arst();
        for (int i = 1; i <= 7; i++) begin
            tick(16'hF00F);
            chk("multi_db_out", db_out, (i >= 6) ? 16'hF00F : 16'h0000);
            chk("multi_mask", change_mask, (i == 6) ? 16'hF00F : 16'h0000);
        end

        // Reset during a bit5 count discards the partial count.
        raw = 16'h0000;
        arst();
        repeat (3) tick(16'h0020);
        arst();
        for (int i = 1; i <= 7; i++) begin
            tick(16'h0020);
            chk("midreset_db_out", db_out, (i >= 6) ? 16'h0020 : 16'h0000);
            chk("midreset_changed", {15'b0, db_changed}, (i == 6) ? 16'h0001 : 16'h0000);
        end

`ifdef DEBOUNCE_EDGE_LATCH_EN
        raw = 16'h0000;
        arst();
        repeat (8) tick(16'h0004);
        chk("latch_held", edge_latch, 16'h0004);
        clr_cur = 16'h0004;
        tick(16'h0004);
        chk("latch_cleared", edge_latch, 16'h0000);
        clr_cur = 16'h0000;
        repeat (5) tick(16'h0000);
        clr_cur = 16'h0004;
        tick(16'h0000);
        chk("latch_set_wins", edge_latch, 16'h0004);
        clr_cur = 16'h0000;
`endif

        // Randomised sparse toggling with occasional glitch bursts and resets.
        r = raw;
        for (int i = 0; i < 2000; i++) begin
            r = r ^ 16'($urandom & $urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) r = r ^ 16'($urandom);
            clr_cur = 16'($urandom & $urandom);
            if ($urandom_range(0, 499) == 0) arst();
            tick(r);
        end
        clr_cur = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/switch_debounce16.md
SWITCH_DEBOUNCE16 -- requirements
Module: switch_debounce16

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable samples required to accept a new level (10 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, meaning synchroniser flop depth per bit; legal range 2..4.
REQ-003 SHALL provide parameter RESET_VALUE, default 16'h0000, meaning db_out value during and after reset.
REQ-004 SHALL have port clk_clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port reset_reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port raw_in  input  16  asynchronous board switch/key levels.
REQ-007 SHALL have port db_out  output  16  debounced levels, registered; feeds pioslave1_external_connection_export of the Embedded system.
REQ-008 SHALL have port db_changed  output  1  one-cycle pulse when any db_out bit updates.
REQ-009 SHALL have port change_mask  output  16  bits updated in the db_changed cycle; zero otherwise.

Function
REQ-010 Each raw_in bit SHALL pass through SYNC_STAGES flops before any comparison; no other logic touches raw_in.
REQ-011 Each bit SHALL own a counter of ceil(log2(DEBOUNCE_CYCLES)) bits, saturating never (cleared before overflow).
REQ-012 Per bit, on each edge: synced != db_out -> counter+1; synced == db_out -> counter cleared to 0.
REQ-013 Per bit, on the edge where synced != db_out and counter == DEBOUNCE_CYCLES-1, db_out bit SHALL take synced value and counter SHALL clear.
REQ-014 Latency: a clean raw_in step held steady SHALL appear on db_out after the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge, counting the first edge that samples the new level as 1.
REQ-015 A disagreement lasting fewer than DEBOUNCE_CYCLES consecutive synced samples SHALL leave db_out unchanged and reset that bit's count.
REQ-016 Bits SHALL be fully independent; simultaneous updates of several bits SHALL produce one db_changed pulse with all updated bits set in change_mask.
REQ-017 db_changed and change_mask SHALL be registered and valid in the same cycle db_out shows the new value; both return to 0 the next cycle unless another bit updates on that edge.
REQ-018 Bit held at its db_out level SHALL never generate db_changed regardless of time.

Reset
REQ-019 Asserting reset_reset_n low SHALL immediately (asynchronously) force db_out=RESET_VALUE, db_changed=0, change_mask=0, all counters=0, all sync flops=RESET_VALUE bits.
REQ-020 Reset release SHALL be synchronous-safe: first counting edge occurs on the first clock edge after deassertion; reset mid-count SHALL discard the partial count.
REQ-021 After reset, raw_in differing from RESET_VALUE SHALL be accepted via the normal REQ-014 latency, with db_changed pulsing.

Configuration
REQ-022 Macro DEBOUNCE_EDGE_LATCH_EN SHALL, when defined, add ports edge_latch (output 16, sticky OR of change_mask) and edge_clear (input 16, write-one-to-clear, registered).
REQ-023 With DEBOUNCE_EDGE_LATCH_EN, a bit set by change_mask and cleared by edge_clear on the same edge SHALL remain set (set wins); reset value of edge_latch SHALL be 0.
REQ-024 Without DEBOUNCE_EDGE_LATCH_EN, edge_latch and edge_clear SHALL not exist and no latch flops SHALL be synthesised; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, RESET_VALUE=0 unless stated)
REQ-025 raw_in 0->16'h0001 held -> db_out=16'h0001 after 6th edge, db_changed=1 and change_mask=16'h0001 for exactly that one cycle.
REQ-026 raw_in bit3 pulses high for 3 cycles then low -> db_out stays 16'h0000, db_changed never asserts.
REQ-027 raw_in 0->16'hF00F in one step -> single db_changed pulse, change_mask=16'hF00F, db_out=16'hF00F after 6th edge.
REQ-028 reset_reset_n pulsed low at edge 3 of a bit5 count -> db_out=0 asynchronously; after release, full 6-edge latency restarts.
REQ-029 RESET_VALUE=16'hFFFF, raw_in=0 during reset -> db_out=16'hFFFF at release, drops to 0 after 6 edges with change_mask=16'hFFFF.
REQ-030 DEBOUNCE_EDGE_LATCH_EN defined: bit2 update -> edge_latch=16'h0004 held; edge_clear=16'h0004 -> 0 next cycle; clear coincident with new bit2 update -> stays 16'h0004.
